// File: rtl/osiris_lbuf_pkg.sv
// Shared types and defaults for the ping-pong linebuffer controller.
package osiris_lbuf_pkg;

    typedef enum logic {
        FREE = 1'b0,
        FULL = 1'b1
    } bank_state_t;

    localparam int DEF_LINES_PER_FRAME = 480;
    localparam int DEF_LCNT_W          = 10;

endpackage

// File: rtl/lbuf_bank_fsm.sv
// One linebuffer bank: FREE until a line lands in it, FULL until the DMA drains it.
module lbuf_bank_fsm
    import osiris_lbuf_pkg::*;
(
    input  logic pclk,
    input  logic rst,
    input  logic set,
    input  logic clr,
    output logic full
);

    bank_state_t state, state_nx;

    // State register; reset abandons whatever the bank held.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state <= FREE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: a clear is applied before a same-cycle set.
    always_comb begin
        state_nx = state;
        case (state)
            FREE: if (set)         state_nx = FULL;
            FULL: if (clr && !set) state_nx = FREE;
            default:               state_nx = FREE;
        endcase
    end

    assign full = (state == FULL);

endmodule

// File: rtl/lbuf_pingpong_ctrl.sv
// Ping-pong linebuffer controller: steers the writer between two banks,
// raises line/frame interrupts toward the processing system and counts lines.
module lbuf_pingpong_ctrl
    import osiris_lbuf_pkg::*;
#(
    parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME,
    parameter int LCNT_W          = DEF_LCNT_W
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              line_done,
    input  logic              frame_start,
    input  logic              dma_ack,
    input  logic              frame_ack,
    input  logic              ovf_clr,
    output logic              wr_bank,
    output logic              wr_en,
    output logic              irq_line,
    output logic              irq_bank,
    output logic              irq_frame,
    output logic              overflow,
    output logic [LCNT_W-1:0] line_count
);

    localparam logic [LCNT_W-1:0] LCNT_ONE = LCNT_W'(1);
    localparam logic [LCNT_W-1:0] LCNT_MAX = '1;
    localparam logic [LCNT_W-1:0] LPF      = LCNT_W'(LINES_PER_FRAME);

    logic [1:0]        full;
    logic [1:0]        full_ack;
    logic [1:0]        full_nx;
    logic [1:0]        set_bank;
    logic [1:0]        clr_bank;
    logic              head;
    logic              head_nx;
    logic              wr_bank_nx;
    logic              wr_en_nx;
    logic              ack_ok;
    logic              ld_drop;
    logic [LCNT_W-1:0] lcnt_nx;
    logic              frame_cond_now;
    logic              frame_cond_nx;
    logic              irq_frame_nx;
    logic              overflow_nx;

    lbuf_bank_fsm u_bank0 (
        .pclk (pclk),
        .rst  (rst),
        .set  (set_bank[0]),
        .clr  (clr_bank[0]),
        .full (full[0])
    );

    lbuf_bank_fsm u_bank1 (
        .pclk (pclk),
        .rst  (rst),
        .set  (set_bank[1]),
        .clr  (clr_bank[1]),
        .full (full[1])
    );

    // Bank steering: the DMA ack is applied first, then the line end is judged.
    // A line ending while both banks are held is rescued, not dropped, when an
    // ack frees a bank in the same cycle.
    always_comb begin
        ack_ok     = dma_ack && (full != 2'b00);
        clr_bank   = 2'b00;
        set_bank   = 2'b00;
        head_nx    = head;
        wr_bank_nx = wr_bank;
        wr_en_nx   = wr_en;
        ld_drop    = 1'b0;
        if (ack_ok) begin
            clr_bank[head] = 1'b1;
            head_nx        = ~head;
            if (!wr_en) begin
                wr_bank_nx = head;
                wr_en_nx   = 1'b1;
            end
        end
        full_ack = full & ~clr_bank;
        if (line_done) begin
            if (wr_en) begin
                set_bank[wr_bank] = 1'b1;
                if (!full_ack[~wr_bank]) begin
                    wr_bank_nx = ~wr_bank;
                end else begin
                    wr_en_nx = 1'b0;
                end
            end else if (!ack_ok) begin
                ld_drop = 1'b1;
            end
        end
        full_nx = full_ack | set_bank;
    end

    // Line counter and sticky flags; irq_frame fires on entering the
    // "frame counted and drained" condition so frame_ack can clear it.
    always_comb begin
        lcnt_nx = line_count;
        if (frame_start) begin
            lcnt_nx = '0;
        end else if (line_done && (line_count != LCNT_MAX)) begin
            lcnt_nx = line_count + LCNT_ONE;
        end
        frame_cond_now = (line_count == LPF) && (full == 2'b00);
        frame_cond_nx  = (lcnt_nx == LPF) && (full_nx == 2'b00);
        irq_frame_nx   = (frame_cond_nx && !frame_cond_now) || (irq_frame && !frame_ack);
        overflow_nx    = ld_drop || (overflow && !ovf_clr);
    end

    // Output and control registers.
    always_ff @(posedge pclk) begin
        if (rst) begin
            head       <= 1'b0;
            wr_bank    <= 1'b0;
            wr_en      <= 1'b1;
            irq_line   <= 1'b0;
            irq_bank   <= 1'b0;
            irq_frame  <= 1'b0;
            overflow   <= 1'b0;
            line_count <= '0;
        end else begin
            head       <= head_nx;
            wr_bank    <= wr_bank_nx;
            wr_en      <= wr_en_nx;
            irq_line   <= |full_nx;
            irq_bank   <= head_nx;
            irq_frame  <= irq_frame_nx;
            overflow   <= overflow_nx;
            line_count <= lcnt_nx;
        end
    end

endmodule

// File: doc/lbuf_pingpong_ctrl.md
LBUF_PINGPONG_CTRL -- requirements
Module: lbuf_pingpong_ctrl

Interface
REQ-001 SHALL have parameter LINES_PER_FRAME, default 480, lines per complete frame.
REQ-002 SHALL have parameter LCNT_W, default 10, width of line_count.
REQ-003 pclk  in  1  pixel clock; sole clock; all logic on its rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 line_done  in  1  one-cycle pulse from the linebuffer writer: the current line is complete in bank wr_bank.
REQ-006 frame_start  in  1  one-cycle pulse derived from vsync: a new frame begins.
REQ-007 dma_ack  in  1  one-cycle pulse from the processing system: copy of bank irq_bank is finished.
REQ-008 frame_ack  in  1  one-cycle pulse: clears irq_frame.
REQ-009 ovf_clr  in  1  one-cycle pulse: clears overflow.
REQ-010 wr_bank  out  1  bank the writer shall fill (0 or 1).
REQ-011 wr_en  out  1  writer may store pixels; 0 = both banks held, line is dropped.
REQ-012 irq_line  out  1  level interrupt: at least one bank is FULL.
REQ-013 irq_bank  out  1  oldest FULL bank; valid while irq_line=1.
REQ-014 irq_frame  out  1  level interrupt: frame complete and fully drained.
REQ-015 overflow  out  1  sticky: at least one line was dropped.
REQ-016 line_count  out  LCNT_W  lines ended in the current frame, dropped lines included.

Function
REQ-017 Each bank SHALL hold one state, FREE or FULL; transitions: FREE->FULL on an accepted line_done for that bank; FULL->FREE on dma_ack while it is irq_bank.
REQ-018 All outputs SHALL be registered; every input event SHALL be reflected on the outputs exactly one pclk after the event.
REQ-019 An accepted line_done (wr_en=1) SHALL mark bank wr_bank FULL; if the other bank is FREE after this cycle's dma_ack is applied, wr_bank SHALL toggle and wr_en SHALL stay 1; otherwise wr_en SHALL go 0.
REQ-020 line_done with wr_en=0 SHALL leave bank states unchanged and SHALL set overflow.
REQ-021 irq_line SHALL equal (bank0 FULL OR bank1 FULL).
REQ-022 A head pointer SHALL track the oldest FULL bank; irq_bank SHALL equal head; head SHALL toggle on each accepted dma_ack.
REQ-023 dma_ack with irq_line=0 SHALL be ignored.
REQ-024 If wr_en=0, dma_ack SHALL free bank irq_bank, set wr_bank to that bank and set wr_en=1.
REQ-025 When line_done and dma_ack fall in the same cycle, the ack SHALL be applied first; when both banks are FULL the freed bank becomes wr_bank and wr_en stays 1.
REQ-026 Every line_done SHALL increment line_count, saturating at 2^LCNT_W-1.
REQ-027 frame_start SHALL clear line_count to 0 and take priority over a same-cycle line_done increment; bank states SHALL be unaffected.
REQ-028 irq_frame SHALL be set when line_count = LINES_PER_FRAME and both banks are FREE; it SHALL hold until frame_ack.
REQ-029 frame_ack and a same-cycle set condition SHALL leave irq_frame set.
REQ-030 ovf_clr and a same-cycle overflow condition SHALL leave overflow set.

Reset
REQ-031 rst SHALL force: both banks FREE, head=0, wr_bank=0, wr_en=1, irq_line=0, irq_bank=0, irq_frame=0, overflow=0, line_count=0.
REQ-032 rst mid-line or mid-DMA SHALL abandon all pending banks; any later dma_ack falls under REQ-023 and is ignored.

Structure
REQ-033 Shared package osiris_lbuf_pkg SHALL hold the bank state enum (FREE, FULL) and the default LINES_PER_FRAME and LCNT_W values.
REQ-034 Per-bank FSM SHALL be sub-module lbuf_bank_fsm, instantiated twice; head/wr_bank/counter logic stays in the top.

Verification
REQ-035 After reset, 1 line_done -> wr_bank=1, wr_en=1, irq_line=1, irq_bank=0.
REQ-036 3 line_done, no ack -> third line dropped, overflow=1, wr_en=0, line_count=3, irq_bank=0; then dma_ack -> wr_bank=0, wr_en=1, irq_bank=1.
REQ-037 Both banks FULL, line_done + dma_ack same cycle -> bank0 freed, wr_bank=0, wr_en=1, overflow=0.
REQ-038 LINES_PER_FRAME=4: 4 lines, each acked -> irq_frame=1 one cycle after the last ack; frame_ack -> 0; frame_start -> line_count=0.
REQ-039 dma_ack with no FULL bank -> no output change; rst asserted while bank0 FULL -> all REQ-031 values next cycle.
